// File: rtl/memacc_pkg.sv
// Shared types and helpers for the memory access controller: FSM states,
// data_size encodings and op classification built on the ALU op codes.
package memacc_pkg;
  `include "aluop.vh"

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DONE    = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW,
      ALU_SB, ALU_SH, ALU_SW: is_mem_op = 1'b1;
      default:                is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      ALU_SB, ALU_SH, ALU_SW: is_store_op = 1'b1;
      default:                is_store_op = 1'b0;
    endcase
  endfunction

  // Non-memory ops map to SIZE_BYTE so an idle/reset controller drives all zeros.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      ALU_LH, ALU_LHU, ALU_SH: op_size = SIZE_HALF;
      ALU_LW, ALU_SW:          op_size = SIZE_WORD;
      default:                 op_size = SIZE_BYTE;
    endcase
  endfunction
endpackage

// File: rtl/aluop.vh
// ALU op codes and ALU exception codes shared by the EX stage and the memory access controller.
`ifndef ALUOP_VH
`define ALUOP_VH

localparam logic [5:0] ALU_ADD  = 6'd0;
localparam logic [5:0] ALU_SUB  = 6'd1;
localparam logic [5:0] ALU_AND  = 6'd2;
localparam logic [5:0] ALU_OR   = 6'd3;
localparam logic [5:0] ALU_XOR  = 6'd4;
localparam logic [5:0] ALU_NOR  = 6'd5;
localparam logic [5:0] ALU_SLL  = 6'd6;
localparam logic [5:0] ALU_SRL  = 6'd7;
localparam logic [5:0] ALU_SRA  = 6'd8;
localparam logic [5:0] ALU_SLT  = 6'd9;
localparam logic [5:0] ALU_SLTU = 6'd10;
localparam logic [5:0] ALU_LUI  = 6'd11;

localparam logic [5:0] ALU_LB   = 6'd32;
localparam logic [5:0] ALU_LBU  = 6'd33;
localparam logic [5:0] ALU_LH   = 6'd34;
localparam logic [5:0] ALU_LHU  = 6'd35;
localparam logic [5:0] ALU_LW   = 6'd36;
localparam logic [5:0] ALU_SB   = 6'd40;
localparam logic [5:0] ALU_SH   = 6'd41;
localparam logic [5:0] ALU_SW   = 6'd42;

localparam logic [2:0] EXC_NONE    = 3'd0;
localparam logic [2:0] EXC_OVF     = 3'd1;
localparam logic [2:0] EXC_ADDRERR = 3'd2;
localparam logic [2:0] EXC_SYSCALL = 3'd3;
localparam logic [2:0] EXC_BREAK   = 3'd4;

`endif

// File: rtl/load_align.sv
// Load data alignment: picks the byte/half lane addressed by addr_lo out of
// the raw bus word and sign- or zero-extends it according to the load op.
module load_align
  import memacc_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  op,
  output logic [31:0] result
);

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = raw[7:0];
      2'd1:    lane_b = raw[15:8];
      2'd2:    lane_b = raw[23:16];
      default: lane_b = raw[31:24];
    endcase
    lane_h = addr_lo[1] ? raw[31:16] : raw[15:0];

    // Size casts of the signed lanes sign-extend; the concatenations zero-extend.
    case (op)
      ALU_LB:  result = 32'(lane_b);
      ALU_LBU: result = {24'd0, lane_b};
      ALU_LH:  result = 32'(lane_h);
      ALU_LHU: result = {16'd0, lane_h};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// EX-stage memory access controller: turns a load/store into one SRAM-like
// request/data transaction, stalls the pipeline meanwhile and handles flushes.
module mem_access_ctrl
  import memacc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  exception_in,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        stall
);

  state_e      state, state_nxt;
  logic        start;
  logic        complete;
  logic [5:0]  op_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] load_data;

  function automatic logic [31:0] store_lanes(input logic [5:0] o, input logic [31:0] w);
    case (o)
      ALU_SB:  store_lanes = {4{w[7:0]}};
      ALU_SH:  store_lanes = {2{w[15:0]}};
      default: store_lanes = w;
    endcase
  endfunction

  assign start = valid_in & is_mem_op(op) & (exception_in == 3'd0) & ~flush;

  // DONE is only ever entered from REQ/WAIT, so this marks the completing cycle.
  assign complete = (state_nxt == ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        // A flush that races an already-finished data phase has nothing left to drain.
        if (flush) begin
          if (data_addr_ok && !data_data_ok) state_nxt = ST_DISCARD;
          else                               state_nxt = ST_IDLE;
        end else if (data_addr_ok) begin
          state_nxt = data_data_ok ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)   state_nxt = ST_DISCARD;
      end
      ST_DONE:    state_nxt = ST_IDLE;
      ST_DISCARD: if (data_data_ok) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Capture stage: request fields are frozen here for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_p0    <= 6'd0;
      addr_p0  <= 32'd0;
      wdata_p0 <= 32'd0;
    end else if (state == ST_IDLE && start) begin
      op_p0    <= op;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  load_align u_load_align (
    .raw     (data_rdata),
    .addr_lo (addr_p0[1:0]),
    .op      (op_p0),
    .result  (load_data)
  );

  // Result stage: rdata_out only changes on a completing transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rdata_out <= 32'd0;
    else if (complete) rdata_out <= is_store_op(op_p0) ? 32'd0 : load_data;
  end

  always_comb begin
    data_req   = (state == ST_REQ);
    data_wr    = is_store_op(op_p0);
    data_size  = op_size(op_p0);
    data_addr  = addr_p0;
    data_wdata = store_lanes(op_p0, wdata_p0);
    done       = (state == ST_DONE);
    // start is combinational from the inputs, so gate it with reset explicitly.
    stall      = rst & (((state == ST_IDLE) & start) | (state == ST_REQ) |
                        (state == ST_WAIT) | (state == ST_DISCARD));
  end

endmodule
